// File: rtl/dmem_responder.sv
// Data-memory responder: services one load/store at a time from a word RAM
// with WAIT_CYCLES wait states, stalling the datapath until the access completes.
module dmem_responder #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rdata_valid,
  output logic              stall,
  output logic              addr_err,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t            state;
  logic [3:0]        wait_cnt;
  logic              lat_write;
  logic              lat_illegal;
  logic [ADDR_W:0]   lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] ram [2**ADDR_W];

  logic              req;
  logic [ADDR_W-1:0] word_idx;
  logic              misaligned;
  logic              ram_we;
  logic              unused_addr_hi;

  // Request/stall handshake: a request is a level on mem_read/mem_write that the
  // datapath holds while stall is high; it is consumed at the end of the cycle in
  // which stall is low (DONE), so the datapath advances exactly once per access.
  assign req        = mem_read | mem_write;
  assign stall      = ((state == S_IDLE) && req) || (state == S_WAIT);
  assign dbg_state  = state;

  // Upper byte-address bits are dropped, so addresses wrap at 2**(ADDR_W+1) bytes.
  assign unused_addr_hi = &{1'b0, addr[15:ADDR_W+1]};
  assign word_idx   = lat_addr[ADDR_W:1];
  assign misaligned = lat_addr[0];
  assign ram_we     = (state == S_DONE) && lat_write && !misaligned && !rst;

  // RAM has no reset: contents survive rst.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      ram[word_idx] <= lat_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      wait_cnt    <= '0;
      lat_write   <= 1'b0;
      lat_illegal <= 1'b0;
      lat_addr    <= '0;
      lat_wdata   <= '0;
      rdata       <= '0;
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      addr_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req) begin
            // A dual strobe is handled as a store and flagged in DONE.
            lat_write   <= mem_write;
            lat_illegal <= mem_read & mem_write;
            lat_addr    <= addr[ADDR_W:0];
            lat_wdata   <= wdata;
            wait_cnt    <= WAIT_INIT;
            state       <= (WAIT_CYCLES == 0) ? S_DONE : S_WAIT;
          end
        end
        S_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          // Inputs still carry the instruction just completed; never re-accept here.
          state    <= S_IDLE;
          addr_err <= misaligned | lat_illegal;
          if (!lat_write) begin
            rdata       <= misaligned ? '0 : ram[word_idx];
            rdata_valid <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, hand-written reset and
// zero-wait sequences, then random accesses checked against a word-array model.
module tb_dmem_responder;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int W2 = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // WAIT_CYCLES=2 instance
  logic          mem_read, mem_write;
  logic [15:0]   addr;
  logic [DW-1:0] wdata, rdata;
  logic          rdata_valid, stall, addr_err;
  logic [1:0]    dbg_state;

  // WAIT_CYCLES=0 instance
  logic          rd0, wr0;
  logic [15:0]   addr0;
  logic [DW-1:0] wdata0, rdata0;
  logic          valid0, stall0, err0;
  logic [1:0]    dbg0;

  dmem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(W2)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .addr(addr), .wdata(wdata), .rdata(rdata), .rdata_valid(rdata_valid),
    .stall(stall), .addr_err(addr_err), .dbg_state(dbg_state)
  );

  dmem_responder #(.DATA_W(DW), .ADDR_W(AW), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .mem_read(rd0), .mem_write(wr0),
    .addr(addr0), .wdata(wdata0), .rdata(rdata0), .rdata_valid(valid0),
    .stall(stall0), .addr_err(err0), .dbg_state(dbg0)
  );

  // ---------------- scoreboard / model state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] mem_model [2**AW];
  logic [DW-1:0] model_rdata;

  logic          pend, pend_v, pend_e, pend_chk;
  logic [DW-1:0] pend_rd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Transaction-level reference: one completed access against a word array.
  task automatic model_access(input logic rd, input logic wr, input logic [15:0] a,
                              input logic [DW-1:0] wd, output logic v, output logic e,
                              output logic [DW-1:0] rx);
    logic [AW-1:0] idx;
    idx = a[AW:1];
    if (wr) begin
      if (!a[0]) mem_model[idx] = wd;
      v = 1'b0;
      e = a[0] | rd;
    end else begin
      model_rdata = a[0] ? '0 : mem_model[idx];
      v = 1'b1;
      e = a[0];
    end
    rx = model_rdata;
  endtask

  // Writeback-cycle outputs of the previous access (or idle zeros).
  task automatic wb_check();
    logic [DW-1:0] q;
    if (pend) begin
      check("wb_rdata_valid", rdata_valid, pend_v);
      check("wb_addr_err", addr_err, pend_e);
      if (pend_v) begin
        if (exp_q.size() == 0) begin
          check("wb_queue_underflow", 1, 0);
        end else begin
          q = exp_q.pop_front();
          check("wb_rdata_load", rdata, q);
        end
      end else if (pend_chk) begin
        check("wb_rdata_held", rdata, pend_rd);
      end
      pend = 1'b0;
    end else begin
      check("idle_rdata_valid", rdata_valid, 0);
      check("idle_addr_err", addr_err, 0);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    wb_check();
    mem_read  = 1'b0;
    mem_write = 1'b0;
    #1;
    check("idle_stall", stall, 0);
  endtask

  // Drives one access, checks the stall profile, leaves writeback expectations pending.
  task automatic do_access(input logic rd, input logic wr, input logic [15:0] a,
                           input logic [DW-1:0] wd, input logic ev, input logic ee,
                           input logic [DW-1:0] erd, input logic chk);
    @(negedge clk);
    wb_check();
    mem_read  = rd;
    mem_write = wr;
    addr      = a;
    wdata     = wd;
    #1;
    check("stall_request", stall, 1);
    for (int k = 0; k < W2; k++) begin
      @(negedge clk);
      #1;
      check("stall_wait", stall, 1);
      check("wait_no_valid", rdata_valid | addr_err, 0);
    end
    @(negedge clk);
    #1;
    check("stall_done", stall, 0);
    check("state_done", dbg_state, 2);
    check("done_no_valid", rdata_valid | addr_err, 0);
    pend     = 1'b1;
    pend_v   = ev;
    pend_e   = ee;
    pend_rd  = erd;
    pend_chk = chk;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic          rd;
    logic          wr;
    logic [15:0]   a;
    logic [DW-1:0] wd;
    logic [DW-1:0] rdx;
    logic          chk;
    logic          v;
    logic          e;
  } vec_t;

  vec_t tbl[11];

  initial begin
    logic          mv, me;
    logic [DW-1:0] mr, d;
    logic [15:0]   a;
    logic          rd, wr;

    tbl[0]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000, 1'b1, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hBEEF, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 1'b1, 16'h0010, 16'hAAAA, 16'hBEEF, 1'b1, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 16'h0011, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hAAAA, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 16'h0011, 16'h5555, 16'hAAAA, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hAAAA, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 16'h0204, 16'h7777, 16'hAAAA, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h7777, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 16'h0030, 16'h4321, 16'h7777, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'h4321, 1'b1, 1'b1, 1'b0};

    rst = 1'b1;
    mem_read = 1'b0; mem_write = 1'b0; addr = '0; wdata = '0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = '0; wdata0 = '0;
    pend = 1'b0; pend_v = 1'b0; pend_e = 1'b0; pend_chk = 1'b0; pend_rd = '0;
    model_rdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_rdata", rdata, 0);
    check("reset_rdata_valid", rdata_valid, 0);
    check("reset_addr_err", addr_err, 0);
    check("reset_stall", stall, 0);
    check("reset_state", dbg_state, 0);
    check("reset0_stall", stall0, 0);
    check("reset0_rdata", rdata0, 0);
    rst = 1'b0;

    // Fill every word through the DUT (upper address bits randomised to exercise wrap)
    for (int i = 0; i < 2**AW; i++) begin
      a = {7'($urandom), 8'(i), 1'b0};
      d = DW'($urandom);
      if (d == 16'h9999) d = 16'h9998;
      model_access(1'b0, 1'b1, a, d, mv, me, mr);
      do_access(1'b0, 1'b1, a, d, mv, me, mr, 1'b1);
    end

    // Directed table
    for (int i = 0; i < 11; i++) begin
      model_access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, mv, me, mr);
      if (tbl[i].v) exp_q.push_back(tbl[i].rdx);
      do_access(tbl[i].rd, tbl[i].wr, tbl[i].a, tbl[i].wd, tbl[i].v, tbl[i].e,
                tbl[i].rdx, tbl[i].chk);
      if (i % 3 == 2) idle_cycle();
    end
    idle_cycle();

    // Reset during WAIT discards the store
    @(negedge clk);
    wb_check();
    mem_write = 1'b1; addr = 16'h0020; wdata = 16'h9999;
    #1;
    check("rst_seq_stall_req", stall, 1);
    @(negedge clk);
    #1;
    check("rst_seq_in_wait", dbg_state, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mem_write = 1'b0;
    #1;
    check("rst_seq_stall", stall, 0);
    check("rst_seq_state", dbg_state, 0);
    check("rst_seq_rdata", rdata, 0);
    check("rst_seq_valid", rdata_valid, 0);
    model_rdata = '0;
    model_access(1'b1, 1'b0, 16'h0020, 16'h0000, mv, me, mr);
    exp_q.push_back(mr);
    do_access(1'b1, 1'b0, 16'h0020, 16'h0000, mv, me, mr, 1'b1);
    idle_cycle();

    // Random accesses against the model
    for (int i = 0; i < 60; i++) begin
      a = 16'($urandom);
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      wr = ($urandom_range(0, 1) == 1);
      rd = !wr || ($urandom_range(0, 7) == 0);
      d  = DW'($urandom);
      model_access(rd, wr, a, d, mv, me, mr);
      if (mv) exp_q.push_back(mr);
      do_access(rd, wr, a, d, mv, me, mr, 1'b1);
      repeat ($urandom_range(0, 2)) idle_cycle();
    end
    idle_cycle();
    check("queue_drained", exp_q.size(), 0);

    // WAIT_CYCLES=0: back-to-back store then load
    @(negedge clk);
    wr0 = 1'b1; addr0 = 16'h0002; wdata0 = 16'h1234;
    #1;
    check("w0_store_stall", stall0, 1);
    @(negedge clk);
    #1;
    check("w0_store_done_stall", stall0, 0);
    check("w0_store_done_state", dbg0, 2);
    @(negedge clk);
    check("w0_store_wb_valid", valid0, 0);
    check("w0_store_wb_err", err0, 0);
    check("w0_not_reaccepted", dbg0, 0);
    wr0 = 1'b0; rd0 = 1'b1; addr0 = 16'h0002;
    #1;
    check("w0_load_stall", stall0, 1);
    @(negedge clk);
    #1;
    check("w0_load_done_stall", stall0, 0);
    check("w0_load_done_state", dbg0, 2);
    @(negedge clk);
    check("w0_load_rdata", rdata0, 16'h1234);
    check("w0_load_valid", valid0, 1);
    check("w0_load_err", err0, 0);
    check("w0_load_not_reaccepted", dbg0, 0);
    rd0 = 1'b0;
    @(negedge clk);
    check("w0_valid_single_pulse", valid0, 0);
    check("w0_idle_stall", stall0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: actual timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory-side end of the mem_read/mem_write strobes that the control unit issues for load (opcode 0000) and store (opcode 0001).
- Holds a word-organised data RAM and services one access at a time with a programmable access latency.
- Drives stall back to the datapath to freeze the PC and pipeline registers until the access completes.
- Returns registered read data for the mem_to_reg writeback mux.

Parameters:
- DATA_W, 16, data word width in bits.
- ADDR_W, 8, word-index width; RAM depth is 2**ADDR_W words.
- WAIT_CYCLES, 2, extra wait-state cycles per access; legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- mem_read  input  1  load request from the control unit.
- mem_write  input  1  store request from the control unit.
- addr  input  16  byte address from the ALU result.
- wdata  input  DATA_W  store data (rt register value).
- rdata  output  DATA_W  registered load data.
- rdata_valid  output  1  one-cycle pulse when rdata updates.
- stall  output  1  freeze request to the datapath.
- addr_err  output  1  one-cycle pulse flagging a faulted access.

Behaviour:
- Reset:
  - One clock: synchronous, active-high rst, as already decided.
  - State=IDLE; rdata=0; rdata_valid=0; addr_err=0; stall=0.
  - RAM contents are not cleared.
  - Reset mid-access returns to IDLE the next edge and discards any pending write; the RAM is unchanged.
- State machine: IDLE, WAIT, DONE.
  - IDLE: if mem_read or mem_write is high, latch op, addr, and wdata, load wait counter = WAIT_CYCLES, and go to WAIT. If WAIT_CYCLES=0, go directly to DONE.
  - WAIT: decrement counter each cycle; when counter = 1, go to DONE. Inputs are ignored while in WAIT.
  - DONE: perform the access from the latched values, then return to IDLE. A request present in DONE is not accepted; it is the just-completed instruction still on the inputs.
- stall is combinational: high when (IDLE and (mem_read or mem_write)) or WAIT; low in DONE. The datapath therefore advances at the end of the DONE cycle.
- Latency:
  - Request first seen in cycle N: stall is high for cycles N..N+WAIT_CYCLES.
  - DONE occurs in cycle N+WAIT_CYCLES+1.
  - rdata and rdata_valid are visible the cycle after DONE, at the writeback edge.
  - Back-to-back memory instructions: the second request is accepted in the IDLE cycle after DONE.
- Address rules:
  - Word index = latched addr[ADDR_W:1].
  - Upper bits addr[15:ADDR_W+1] are ignored, so addresses wrap modulo 2**(ADDR_W+1) bytes.
  - addr[0]=1 (misaligned): the access is suppressed (no RAM write; rdata forced to 0 for reads) and addr_err pulses. Latency is unchanged.
- Read in DONE: rdata <= RAM[index]; rdata_valid pulses for 1 cycle.
- rdata holds its value until the next completed read; writes and faults on writes do not alter it.
- Write in DONE: RAM[index] <= wdata; rdata_valid stays 0.
- mem_read and mem_write both high in IDLE: illegal. Treated as a write; addr_err pulses in DONE.
- addr_err is registered and asserted in the cycle after DONE, aligned with rdata_valid.
- No request in IDLE: stall=0 and the block is idle, with no spurious pulses.

Test Plan:
- Store then load, WAIT_CYCLES=2: store wdata=0xBEEF at addr 0x0010 → stall high 3 cycles, no rdata_valid. Then load from 0x0010 → stall high 3 cycles, then rdata=0xBEEF with a 1-cycle rdata_valid pulse.
- WAIT_CYCLES=0, back-to-back: store 0x1234 at 0x0002, then load from 0x0002 the next instruction → each access stalls exactly 1 cycle; rdata=0x1234 after the second DONE; the load is not accepted during the store's DONE cycle.
- Misaligned load at 0x0011, after RAM word 8 = 0xAAAA → addr_err pulse, rdata=0x0000, RAM word 8 still 0xAAAA. Misaligned store at 0x0011 with 0x5555 → RAM word 8 unchanged.
- Wrap, ADDR_W=8: store 0x7777 at 0x0204 → load from 0x0004 returns 0x7777.
- Reset mid-access: store 0x9999 at 0x0020, assert rst during WAIT → stall=0 and state IDLE the next cycle; a subsequent load from 0x0020 returns the prior contents, not 0x9999.
- Illegal dual strobe: mem_read=mem_write=1 with wdata=0x4321 at 0x0030 → addr_err pulses, RAM word 0x18 = 0x4321, rdata unchanged, rdata_valid stays 0.
